// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types for the IF/DM memory-port arbiter. Holds the arbiter
//            state encoding, the one-cycle grant decision encoding and the
//            width of the fairness streak counter.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

   localparam int STREAK_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_IF   = 2'd1,
      GNT_DM   = 2'd2
   } grant_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_streak_ctr.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_streak_ctr
// Purpose  : Fairness guard for the memory-port arbiter. Counts consecutive
//            DM grants made while IF is waiting and trips once the count
//            reaches MAX_STREAK with IF still requesting.
// Ports    : clk, reset  - clock, asynchronous active-high reset
//            grant       - grant being made this cycle (GNT_NONE when busy)
//            if_req      - IF request level
//            trip        - IF must win the next IDLE grant
// Revision : 1.0  initial release
// ============================================================================
module mem_arb_streak_ctr
   import mem_arb_pkg::*;
#(
   parameter int MAX_STREAK = 4
) (
   input  logic   clk,
   input  logic   reset,
   input  grant_t grant,
   input  logic   if_req,
   output logic   trip
);

   localparam logic [STREAK_W-1:0] TRIP_AT = STREAK_W'(MAX_STREAK);

   logic [STREAK_W-1:0] r_streak;

   // The counter never passes TRIP_AT: once it trips with IF waiting, the
   // next grant is IF, which clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_streak <= '0;
      end else begin
         case (grant)
            GNT_IF:  r_streak <= '0;
            GNT_DM:  r_streak <= if_req ? r_streak + 1'b1 : '0;
            default: r_streak <= r_streak;
         endcase
      end
   end

   assign trip = if_req && (r_streak == TRIP_AT);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one 32-bit memory port between instruction fetch (IF)
//            and data memory (DM). One transaction at a time; DM has priority.
//            Build option MEM_ARB_FAIRNESS_EN adds a streak guard that lets
//            IF win after MAX_STREAK consecutive DM grants made while IF waits.
// Ports    : clk, reset                       - clock, async active-high reset
//            if_req/if_addr -> if_ack/if_rdata - IF read requester
//            dm_req/dm_we/dm_addr/dm_wdata
//                         -> dm_ack/dm_rdata   - DM load/store requester
//            mem_req/mem_we/mem_addr/mem_wdata - registered memory request
//            mem_ack/mem_rdata                 - memory completion and data
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MAX_STREAK = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ack,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t r_state;
   grant_t     w_grant;
   logic       w_trip;

   // Grants are only made from IDLE; the ack edge always returns to IDLE
   // first, so requests seen at that edge wait one cycle.
   always_comb begin
      w_grant = GNT_NONE;
      if (r_state == IDLE) begin
         if (dm_req && !w_trip) begin
            w_grant = GNT_DM;
         end else if (if_req) begin
            w_grant = GNT_IF;
         end
      end
   end

`ifdef MEM_ARB_FAIRNESS_EN
   mem_arb_streak_ctr #(
      .MAX_STREAK (MAX_STREAK)
   ) u_streak_ctr (
      .clk    (clk),
      .reset  (reset),
      .grant  (w_grant),
      .if_req (if_req),
      .trip   (w_trip)
   );
`else
   assign w_trip = 1'b0;

   // MAX_STREAK only matters with the fairness guard built in.
   logic unused_max_streak;
   assign unused_max_streak = ^STREAK_W'(MAX_STREAK);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               case (w_grant)
                  GNT_DM: begin
                     r_state   <= BUSY_DM;
                     mem_req   <= 1'b1;
                     mem_we    <= dm_we;
                     mem_addr  <= dm_addr;
                     mem_wdata <= dm_wdata;
                  end
                  GNT_IF: begin
                     r_state   <= BUSY_IF;
                     mem_req   <= 1'b1;
                     mem_we    <= 1'b0;
                     mem_addr  <= if_addr;
                     mem_wdata <= '0;
                  end
                  default: begin
                     mem_req <= 1'b0;
                  end
               endcase
            end
            BUSY_IF, BUSY_DM: begin
               // Operands stay put until the memory completes.
               if (mem_ack) begin
                  r_state <= IDLE;
                  mem_req <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   assign if_ack   = (r_state == BUSY_IF) && mem_ack;
   assign dm_ack   = (r_state == BUSY_DM) && mem_ack;
   assign if_rdata = if_ack ? mem_rdata : '0;
   // A DM write acknowledges with zero data whatever the memory drives.
   assign dm_rdata = (dm_ack && !mem_we) ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one shared 32-bit memory port between the pipeline's instruction-fetch requester (IF) and data-memory requester (DM, loads/stores). It sits between the IF/MEM stages and the unified memory. It grants one transaction at a time, drives the memory-side request/ack handshake, and routes the acknowledge and read data back to the winning requester. DM has priority, and an optional fairness guard bounds IF starvation.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_STREAK, 4, consecutive DM grants allowed while IF waits (fairness guard only); legal range 1..15
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  IF requests a read; held with if_addr stable until if_ack
- if_addr  in  ADDR_W  IF read address
- if_ack  out  1  IF transaction complete this cycle
- if_rdata  out  DATA_W  IF read data, valid when if_ack
- dm_req  in  1  DM request; held with dm_we/dm_addr/dm_wdata stable until dm_ack
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  DM address
- dm_wdata  in  DATA_W  DM write data
- dm_ack  out  1  DM transaction complete this cycle
- dm_rdata  out  DATA_W  DM read data, valid when dm_ack and !dm_we
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_ack  in  1  memory completes the current request; legal any cycle mem_req=1, including the first
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE, dm_req=1 and the guard has not tripped: go to BUSY_DM. Latch dm_we, dm_addr and dm_wdata into the mem_* registers and set mem_req=1.
- IDLE, IF wins (dm_req=0, or the guard has tripped): go to BUSY_IF. Latch if_addr, set mem_we=0 and mem_wdata=0, and set mem_req=1.
- IDLE, no request: stay in IDLE with mem_req=0.
- BUSY_x, mem_ack=0: hold all mem_* outputs.
- BUSY_x, mem_ack=1: go to IDLE and clear mem_req. Requests sampled at this edge are ignored; they are re-evaluated at the next edge from IDLE.
- if_ack = (state==BUSY_IF) && mem_ack, combinational.
- dm_ack = (state==BUSY_DM) && mem_ack, combinational.
- if_rdata and dm_rdata pass mem_rdata through combinationally. Each reads as 0 when its ack is low.
- Requesters update req and operands on the edge at which they sample ack=1.
- Requests are never dropped. A requester that withdraws req before ack is a protocol violation, and behaviour in that case is undefined.
- DM writes return dm_ack with dm_rdata=0.

## Timing
- Reset values: state=IDLE; mem_req, mem_we, mem_addr, mem_wdata = 0; if_ack, dm_ack = 0; streak counter = 0.
- Minimum latency: the request is sampled at edge N, mem_req rises after edge N, and ack comes in cycle N+1 if the memory acks immediately.
- Minimum occupancy is 2 cycles per transaction. A new grant is made at the edge after the ack edge.
- Simultaneous if_req and dm_req in IDLE: DM wins unless the guard has tripped.
- Reset asserted mid-transaction: return to IDLE immediately and drop mem_req. The in-flight access is abandoned with no ack, and the memory must tolerate this.
- mem_ack while IDLE is ignored.

## Configuration
- MEM_ARB_FAIRNESS_EN defined:
  - A 4-bit streak counter increments on each DM grant made while if_req=1.
  - It clears on any IF grant, and on any DM grant made while if_req=0.
  - When streak==MAX_STREAK and if_req=1, IF wins the next IDLE grant regardless of dm_req.
- MEM_ARB_FAIRNESS_EN undefined: strict DM priority, no counter is instantiated, and IF can starve indefinitely.

## Structure
- mem_arb_pkg holds:
  - the state enum (IDLE, BUSY_IF, BUSY_DM);
  - the grant encoding (GNT_NONE, GNT_IF, GNT_DM);
  - localparam STREAK_W = 4.
- Sub-module mem_arb_streak_ctr contains the fairness counter and trip compare. It is instantiated only under MEM_ARB_FAIRNESS_EN.

## Test plan
- Single IF read: if_req=1, if_addr=0x4, memory acks one cycle after mem_req with 0x21420002. Expect mem_addr=0x4, mem_we=0, if_ack for one cycle, if_rdata=0x21420002, dm_ack=0 throughout.
- DM write with a 3-cycle memory delay: dm_we=1, dm_addr=0x10, dm_wdata=0xDEADBEEF. Expect mem_* held for 3 cycles, then dm_ack and dm_rdata=0.
- Simultaneous requests: if_req and dm_req both raised in IDLE. Expect DM granted first, then IF granted at the edge after dm_ack, and if_ack 2 cycles later with zero-wait memory.
- Starvation with MEM_ARB_FAIRNESS_EN and MAX_STREAK=4: dm_req held continuously with a new address after every ack, and if_req held. Expect exactly 4 DM grants, then 1 IF grant, then DM resumes. Without the macro, expect no IF grant.
- Reset mid-transaction: assert reset while BUSY_DM with mem_ack=0. Expect mem_req=0, no dm_ack, and state IDLE immediately. After release, a pending dm_req is re-granted.
- Stray ack: mem_ack=1 while IDLE. Expect no if_ack or dm_ack and no state change.
